// File: rtl/rgb565_gray_pipe_ise_if.sv
// Custom-instruction bus bundle for the RGB565 grayscale ISE.
// The CPU side drives the request fields; the ISE returns done/result.
interface rgb565_gray_pipe_ise_if;
    logic        start;
    logic [7:0]  iseId;
    logic [31:0] valueA;
    logic [31:0] valueB;
    logic        done;
    logic [31:0] result;

    modport master (
        output start, iseId, valueA, valueB,
        input  done, result
    );

    modport slave (
        input  start, iseId, valueA, valueB,
        output done, result
    );
endinterface

// File: rtl/rgb565_gray_pipe_ise.sv
// Pipelined custom instruction: four packed RGB565 pixels -> four 8-bit gray
// values using programmable Q0.8 luma weights and optional rounding.
// One operation in flight at a time; a per-stage valid bit tracks it.
module rgb565_gray_pipe_ise #(
    parameter logic [7:0] customInstructionId = 8'd15,
    parameter int         PIPE_STAGES         = 2,
    parameter logic [7:0] R_W                 = 8'd77,
    parameter logic [7:0] G_W                 = 8'd150,
    parameter logic [7:0] B_W                 = 8'd29,
    parameter bit         ROUND               = 1'b1
) (
    input logic                    clock,
    input logic                    reset,
    rgb565_gray_pipe_ise_if.slave  bus
);

    // Expand one pixel and form its three weighted products {R, G, B}.
    function automatic logic [47:0] lane_products(input logic [15:0] px);
        logic [7:0] r8, g8, b8;
        r8 = {px[15:11], px[15:13]};
        g8 = {px[10:5],  px[10:9]};
        b8 = {px[4:0],   px[4:2]};
        return {16'(R_W) * 16'(r8), 16'(G_W) * 16'(g8), 16'(B_W) * 16'(b8)};
    endfunction

    // Unrounded sum of the three products (fits 18 bits with headroom for +128).
    function automatic logic [17:0] lane_sum(input logic [47:0] p);
        return 18'(p[47:32]) + 18'(p[31:16]) + 18'(p[15:0]);
    endfunction

    // Round, take the integer part and saturate to 8 bits.
    function automatic logic [7:0] lane_gray(input logic [17:0] s);
        logic [17:0] t;
        t = s + (ROUND ? 18'd128 : 18'd0);
        return (t[17:16] != 2'b00) ? 8'hFF : t[15:8];
    endfunction

    logic                  r_busy;
    logic                  r_done;
    logic [31:0]           r_result;
    logic                  w_accept;
    logic                  w_fin_valid;
    logic [3:0][15:0]      w_px;
    logic [3:0][47:0]      w_prod_in;
    logic [3:0][7:0]       w_gray;

    assign w_accept = bus.start && (bus.iseId == customInstructionId) && !r_busy;
    assign w_px     = {bus.valueB[15:0], bus.valueB[31:16],
                       bus.valueA[15:0], bus.valueA[31:16]};

    // Products straight from the live operands: the first register stage
    // captures these, so operands are consumed in the accepting cycle.
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            w_prod_in[i] = lane_products(w_px[i]);
        end
    end

    if (PIPE_STAGES == 1) begin : g_p1
        assign w_fin_valid = w_accept;

        // Whole datapath feeds the result register in the accepting cycle.
        always_comb begin
            for (int unsigned i = 0; i < 4; i++) begin
                w_gray[i] = lane_gray(lane_sum(w_prod_in[i]));
            end
        end
    end else if (PIPE_STAGES == 2) begin : g_p2
        logic             r_v1;
        logic [3:0][47:0] r_prod;

        // Product register stage with its valid bit.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                r_v1   <= 1'b0;
                r_prod <= '0;
            end else begin
                r_v1 <= w_accept;
                if (w_accept) r_prod <= w_prod_in;
            end
        end

        assign w_fin_valid = r_v1;

        // Sum, round and saturate from the registered products.
        always_comb begin
            for (int unsigned i = 0; i < 4; i++) begin
                w_gray[i] = lane_gray(lane_sum(r_prod[i]));
            end
        end
    end else if (PIPE_STAGES == 3) begin : g_p3
        logic             r_v1;
        logic             r_v2;
        logic [3:0][47:0] r_prod;
        logic [3:0][17:0] r_sum;

        // Product and sum register stages with their valid bits.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                r_v1   <= 1'b0;
                r_v2   <= 1'b0;
                r_prod <= '0;
                r_sum  <= '0;
            end else begin
                r_v1 <= w_accept;
                r_v2 <= r_v1;
                if (w_accept) r_prod <= w_prod_in;
                if (r_v1) begin
                    for (int unsigned i = 0; i < 4; i++) begin
                        r_sum[i] <= lane_sum(r_prod[i]);
                    end
                end
            end
        end

        assign w_fin_valid = r_v2;

        // Round and saturate from the registered sums.
        always_comb begin
            for (int unsigned i = 0; i < 4; i++) begin
                w_gray[i] = lane_gray(r_sum[i]);
            end
        end
    end else begin : g_bad
        $error("rgb565_gray_pipe_ise: PIPE_STAGES must be 1, 2 or 3");
        assign w_fin_valid = 1'b0;
        assign w_gray      = '0;
    end

    // Output strobe/result and the busy flag; busy drops on the edge that
    // raises done, which for a single stage means it never rises at all.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_busy   <= (r_busy | w_accept) & ~w_fin_valid;
            r_done   <= w_fin_valid;
            r_result <= w_fin_valid ? w_gray : '0;
        end
    end

    assign bus.done   = r_done;
    assign bus.result = r_result;

endmodule

// File: tb/tb_rgb565_gray_pipe_ise.sv
// Self-checking bench: five parameterisations share one stimulus stream and
// are compared cycle by cycle against an arithmetic reference model.
module tb_rgb565_gray_pipe_ise;

    localparam int N = 5;   // 0:default 1:ROUND=0 2:PIPE=1 3:PIPE=3 4:weights 255
    localparam int W = 8;   // observed cycles per operation window
    localparam int PS [N] = '{2, 2, 1, 3, 2};
    localparam int RW [N] = '{77, 77, 77, 77, 255};
    localparam int GW [N] = '{150, 150, 150, 150, 255};
    localparam int BW [N] = '{29, 29, 29, 29, 255};
    localparam int RN [N] = '{1, 0, 1, 1, 1};

    logic        clock = 1'b0;
    logic        reset;
    logic        t_start;
    logic [7:0]  t_id;
    logic [31:0] t_a, t_b;
    logic        w_done [N];
    logic [31:0] w_res  [N];

    always #5 clock = ~clock;

    rgb565_gray_pipe_ise_if ifs [N] ();

    for (genvar g = 0; g < N; g++) begin : g_bus
        assign ifs[g].start  = t_start;
        assign ifs[g].iseId  = t_id;
        assign ifs[g].valueA = t_a;
        assign ifs[g].valueB = t_b;
        assign w_done[g]     = ifs[g].done;
        assign w_res[g]      = ifs[g].result;
    end

    rgb565_gray_pipe_ise #(.customInstructionId(8'd15), .PIPE_STAGES(2), .R_W(8'd77),
        .G_W(8'd150), .B_W(8'd29), .ROUND(1'b1))
        u_def (.clock(clock), .reset(reset), .bus(ifs[0]));
    rgb565_gray_pipe_ise #(.customInstructionId(8'd15), .PIPE_STAGES(2), .R_W(8'd77),
        .G_W(8'd150), .B_W(8'd29), .ROUND(1'b0))
        u_trn (.clock(clock), .reset(reset), .bus(ifs[1]));
    rgb565_gray_pipe_ise #(.customInstructionId(8'd15), .PIPE_STAGES(1), .R_W(8'd77),
        .G_W(8'd150), .B_W(8'd29), .ROUND(1'b1))
        u_p1 (.clock(clock), .reset(reset), .bus(ifs[2]));
    rgb565_gray_pipe_ise #(.customInstructionId(8'd15), .PIPE_STAGES(3), .R_W(8'd77),
        .G_W(8'd150), .B_W(8'd29), .ROUND(1'b1))
        u_p3 (.clock(clock), .reset(reset), .bus(ifs[3]));
    rgb565_gray_pipe_ise #(.customInstructionId(8'd15), .PIPE_STAGES(2), .R_W(8'd255),
        .G_W(8'd255), .B_W(8'd255), .ROUND(1'b1))
        u_sat (.clock(clock), .reset(reset), .bus(ifs[4]));

    int          checks   = 0;
    int          failures = 0;
    logic        obs_done [N][W];
    logic [31:0] obs_res  [N][W];
    logic        exp_done [N][W];
    logic [31:0] exp_res  [N][W];

    // Reference luma for one pixel with plain integer arithmetic.
    function automatic int unsigned gray8(input logic [15:0] px, input int d);
        int unsigned r5, g6, b5, r8, g8, b8, s;
        r5 = px[15:11]; g6 = px[10:5]; b5 = px[4:0];
        r8 = r5 * 8 + r5 / 4;
        g8 = g6 * 4 + g6 / 16;
        b8 = b5 * 8 + b5 / 4;
        s  = RW[d] * r8 + GW[d] * g8 + BW[d] * b8 + (RN[d] != 0 ? 128 : 0);
        s  = s / 256;
        return (s > 255) ? 255 : s;
    endfunction

    function automatic logic [31:0] pack4(input int d, input logic [31:0] a, input logic [31:0] b);
        return {8'(gray8(b[15:0], d)), 8'(gray8(b[31:16], d)),
                8'(gray8(a[15:0], d)), 8'(gray8(a[31:16], d))};
    endfunction

    // Expected done/result per cycle: the operation accepted at the window's
    // first edge completes P cycles later unless reset intervenes; a second
    // start at offset es is taken only once the first done has been raised.
    task automatic model_window(input logic [31:0] a, input logic [31:0] b, input logic [7:0] id,
                                input logic [31:0] a2, input logic [31:0] b2, input int es, input int rs);
        for (int d = 0; d < N; d++) begin
            for (int c = 0; c < W; c++) begin
                exp_done[d][c] = 1'b0;
                exp_res[d][c]  = 32'd0;
            end
            if (id == 8'd15 && (rs < 0 || PS[d] - 1 < rs)) begin
                exp_done[d][PS[d] - 1] = 1'b1;
                exp_res[d][PS[d] - 1]  = pack4(d, a, b);
            end
            if (id == 8'd15 && es >= PS[d] && es + PS[d] - 1 < W) begin
                exp_done[d][es + PS[d] - 1] = 1'b1;
                exp_res[d][es + PS[d] - 1]  = pack4(d, a2, b2);
            end
        end
    endtask

    // Issue one request, then record every DUT's outputs for W cycles.
    // Idle cycles carry random operand noise with start low.
    task automatic run_window(input logic [31:0] a, input logic [31:0] b, input logic [7:0] id,
                              input logic [31:0] a2, input logic [31:0] b2, input int es, input int rs);
        @(negedge clock);
        t_start = 1'b1; t_id = id; t_a = a; t_b = b;
        for (int c = 0; c < W; c++) begin
            @(posedge clock);
            @(negedge clock);
            for (int d = 0; d < N; d++) begin
                obs_done[d][c] = w_done[d];
                obs_res[d][c]  = w_res[d];
            end
            t_start = 1'b0; t_id = 8'd15; t_a = $urandom; t_b = $urandom;
            if (c + 1 == es) begin
                t_start = 1'b1; t_a = a2; t_b = b2;
            end
            if (rs >= 0) reset = (c + 1 == rs);
        end
        t_start = 1'b0;
        reset   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; t_start = 1'b0; t_id = 8'd0; t_a = '0; t_b = '0;
        repeat (2) @(negedge clock);
        for (int d = 0; d < N; d++) begin
            checks++;
            if (w_done[d] !== 1'b0) begin
                failures++;
                $display("FAIL reset_done dut%0d got %b want 0", d, w_done[d]);
            end
            checks++;
            if (w_res[d] !== 32'd0) begin
                failures++;
                $display("FAIL reset_result dut%0d got %h want 00000000", d, w_res[d]);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_directed();
        model_window(32'hFFFF_0000, 32'hF800_07E0, 8'd15, '0, '0, -1, -1);
        run_window(32'hFFFF_0000, 32'hF800_07E0, 8'd15, '0, '0, -1, -1);
        for (int d = 0; d < N; d++) begin
            for (int c = 0; c < W; c++) begin
                checks++;
                if (obs_done[d][c] !== exp_done[d][c]) begin
                    failures++;
                    $display("FAIL directed_done dut%0d cyc%0d got %b want %b", d, c, obs_done[d][c], exp_done[d][c]);
                end
                checks++;
                if (obs_res[d][c] !== exp_res[d][c]) begin
                    failures++;
                    $display("FAIL directed_result dut%0d cyc%0d got %h want %h", d, c, obs_res[d][c], exp_res[d][c]);
                end
            end
        end
        checks++;
        if (obs_res[0][1] !== 32'h954D_00FF) begin
            failures++;
            $display("FAIL directed_round got %h want 954d00ff", obs_res[0][1]);
        end
        checks++;
        if (obs_res[1][1] !== 32'h954C_00FF) begin
            failures++;
            $display("FAIL directed_trunc got %h want 954c00ff", obs_res[1][1]);
        end
    endtask

    task automatic test_blue_latency();
        model_window(32'h001F_0000, 32'd0, 8'd15, '0, '0, -1, -1);
        run_window(32'h001F_0000, 32'd0, 8'd15, '0, '0, -1, -1);
        for (int d = 0; d < N; d++) begin
            for (int c = 0; c < W; c++) begin
                checks++;
                if (obs_done[d][c] !== exp_done[d][c]) begin
                    failures++;
                    $display("FAIL blue_done dut%0d cyc%0d got %b want %b", d, c, obs_done[d][c], exp_done[d][c]);
                end
                checks++;
                if (obs_res[d][c] !== exp_res[d][c]) begin
                    failures++;
                    $display("FAIL blue_result dut%0d cyc%0d got %h want %h", d, c, obs_res[d][c], exp_res[d][c]);
                end
            end
        end
        // Latency sweep: PIPE 1/2/3 live in DUTs 2/0/3.
        checks++;
        if (obs_done[2][0] !== 1'b1 || obs_res[2][0] !== 32'd29) begin
            failures++;
            $display("FAIL blue_pipe1 got done=%b res=%h want done=1 res=0000001d", obs_done[2][0], obs_res[2][0]);
        end
        checks++;
        if (obs_done[0][1] !== 1'b1 || obs_res[0][1] !== 32'd29) begin
            failures++;
            $display("FAIL blue_pipe2 got done=%b res=%h want done=1 res=0000001d", obs_done[0][1], obs_res[0][1]);
        end
        checks++;
        if (obs_done[3][2] !== 1'b1 || obs_res[3][2] !== 32'd29) begin
            failures++;
            $display("FAIL blue_pipe3 got done=%b res=%h want done=1 res=0000001d", obs_done[3][2], obs_res[3][2]);
        end
    endtask

    task automatic test_saturate();
        model_window(32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'd15, '0, '0, -1, -1);
        run_window(32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'd15, '0, '0, -1, -1);
        for (int d = 0; d < N; d++) begin
            for (int c = 0; c < W; c++) begin
                checks++;
                if (obs_res[d][c] !== exp_res[d][c]) begin
                    failures++;
                    $display("FAIL sat_result dut%0d cyc%0d got %h want %h", d, c, obs_res[d][c], exp_res[d][c]);
                end
            end
        end
        checks++;
        if (obs_res[4][1] !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL sat_heavy got %h want ffffffff", obs_res[4][1]);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        for (int n = 0; n < 12; n++) begin
            a = $urandom; b = $urandom;
            model_window(a, b, 8'd15, '0, '0, -1, -1);
            run_window(a, b, 8'd15, '0, '0, -1, -1);
            for (int d = 0; d < N; d++) begin
                for (int c = 0; c < W; c++) begin
                    checks++;
                    if (obs_done[d][c] !== exp_done[d][c] || obs_res[d][c] !== exp_res[d][c]) begin
                        failures++;
                        $display("FAIL random%0d dut%0d cyc%0d got %b/%h want %b/%h", n, d, c,
                                 obs_done[d][c], obs_res[d][c], exp_done[d][c], exp_res[d][c]);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, a2, b2;
        int pulses;
        a = $urandom; b = $urandom; a2 = ~a; b2 = ~b;
        model_window(a, b, 8'd15, a2, b2, 1, -1);
        run_window(a, b, 8'd15, a2, b2, 1, -1);
        for (int d = 0; d < N; d++) begin
            for (int c = 0; c < W; c++) begin
                checks++;
                if (obs_done[d][c] !== exp_done[d][c] || obs_res[d][c] !== exp_res[d][c]) begin
                    failures++;
                    $display("FAIL busy dut%0d cyc%0d got %b/%h want %b/%h", d, c,
                             obs_done[d][c], obs_res[d][c], exp_done[d][c], exp_res[d][c]);
                end
            end
        end
        pulses = 0;
        for (int c = 0; c < W; c++) pulses += int'(obs_done[3][c]);
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("FAIL busy_pulses got %0d want 1", pulses);
        end
    endtask

    task automatic test_bad_id();
        logic [31:0] a, b;
        a = $urandom; b = $urandom;
        model_window(a, b, 8'd14, '0, '0, -1, -1);
        run_window(a, b, 8'd14, '0, '0, -1, -1);
        for (int d = 0; d < N; d++) begin
            for (int c = 0; c < W; c++) begin
                checks++;
                if (obs_done[d][c] !== exp_done[d][c] || obs_res[d][c] !== exp_res[d][c]) begin
                    failures++;
                    $display("FAIL bad_id dut%0d cyc%0d got %b/%h want %b/%h", d, c,
                             obs_done[d][c], obs_res[d][c], exp_done[d][c], exp_res[d][c]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] a, b;
        for (int pass = 0; pass < 2; pass++) begin
            a = $urandom; b = $urandom;
            model_window(a, b, 8'd15, '0, '0, -1, (pass == 0) ? 1 : -1);
            run_window(a, b, 8'd15, '0, '0, -1, (pass == 0) ? 1 : -1);
            for (int d = 0; d < N; d++) begin
                for (int c = 0; c < W; c++) begin
                    checks++;
                    if (obs_done[d][c] !== exp_done[d][c] || obs_res[d][c] !== exp_res[d][c]) begin
                        failures++;
                        $display("FAIL reset_mid%0d dut%0d cyc%0d got %b/%h want %b/%h", pass, d, c,
                                 obs_done[d][c], obs_res[d][c], exp_done[d][c], exp_res[d][c]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_blue_latency();
        test_saturate();
        test_random();
        test_back_to_back();
        test_bad_id();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
